// File: rtl/y86_execute_stage.sv
// ---------------------------------------------------------------------------
// y86_execute_stage
//
// Execute stage of a pipelined Y86-64 processor. It reads the decode-to-execute
// (E) register fields, picks the ALU operands, computes valE, and maintains the
// {ZF,SF,OF} condition-code register. It also evaluates jXX/cmovXX conditions
// and registers the results into the execute-to-memory (M) pipeline register.
//
// Optional feature macro: EXE_PERF_CNT_EN
//   Adds the instruction counter perf_insn_cnt and the taken-jump counter
//   perf_taken_cnt. Both are 32 bits wide.
//
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   E_*                    : decode-to-execute register fields
//   M_stall, M_bubble      : M register hold / NOP injection
//   cc_block               : downstream exception, suppresses the CC update
//   e_valE, e_dstE, e_Cnd  : combinational results for forwarding/mispredict
//   M_*                    : execute-to-memory pipeline register
//   cc_out                 : {ZF,SF,OF}
//   perf_*                 : event counters (EXE_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module y86_execute_stage #(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             E_valid,
  input  logic [2:0]       E_stat,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_ifun,
  input  logic [WIDTH-1:0] E_valC,
  input  logic [WIDTH-1:0] E_valA,
  input  logic [WIDTH-1:0] E_valB,
  input  logic [3:0]       E_dstE,
  input  logic [3:0]       E_dstM,
  input  logic             M_stall,
  input  logic             M_bubble,
  input  logic             cc_block,
  output logic [WIDTH-1:0] e_valE,
  output logic [3:0]       e_dstE,
  output logic             e_Cnd,
  output logic             M_valid,
  output logic [2:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_Cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM,
`ifdef EXE_PERF_CNT_EN
  output logic [31:0]      perf_insn_cnt,
  output logic [31:0]      perf_taken_cnt,
`endif
  output logic [2:0]       cc_out
);

  // Instruction codes
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // ALU functions
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  // Status codes and the "no register" id
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_INS = 3'd4;
  localparam logic [3:0] R_NONE = 4'hF;

  localparam logic [WIDTH-1:0] EIGHT = WIDTH'(8);

  typedef struct packed {
    logic             valid;
    logic [2:0]       stat;
    logic [3:0]       icode;
    logic             cnd;
    logic [WIDTH-1:0] val_e;
    logic [WIDTH-1:0] val_a;
    logic [3:0]       dst_e;
    logic [3:0]       dst_m;
  } m_reg_t;

  localparam m_reg_t M_BUBBLE = '{
    valid: 1'b0, stat: S_AOK, icode: I_NOP, cnd: 1'b0,
    val_e: '0, val_a: '0, dst_e: R_NONE, dst_m: R_NONE
  };

  // Shared 64-bit ALU: result and signed overflow for the four OPq functions.
  function automatic logic [WIDTH-1:0] alu_calc(input logic [3:0] fun,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (fun)
      ALU_ADD: return b + a;
      ALU_SUB: return b - a;
      ALU_AND: return b & a;
      ALU_XOR: return b ^ a;
      default: return '0;
    endcase
  endfunction

  function automatic logic alu_overflow(input logic [3:0] fun,
                                        input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b,
                                        input logic [WIDTH-1:0] res);
    logic sa, sb, sr;
    sa = a[WIDTH-1];
    sb = b[WIDTH-1];
    sr = res[WIDTH-1];
    case (fun)
      ALU_ADD: return (sa == sb) && (sr != sa);
      ALU_SUB: return (sa != sb) && (sr != sb);
      default: return 1'b0;
    endcase
  endfunction

  // Branch / conditional-move condition from {ZF,SF,OF}.
  function automatic logic cond_eval(input logic [3:0] fun, input logic [2:0] cc);
    logic zf, sf, of;
    zf = cc[2];
    sf = cc[1];
    of = cc[0];
    case (fun)
      4'd0:    return 1'b1;
      4'd1:    return (sf ^ of) | zf;
      4'd2:    return sf ^ of;
      4'd3:    return zf;
      4'd4:    return !zf;
      4'd5:    return !(sf ^ of);
      4'd6:    return !(sf ^ of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  logic [WIDTH-1:0] alu_a, alu_b, alu_res;
  logic [3:0]       alu_fun;
  logic             illegal_op;
  logic             set_cc;
  logic [2:0]       cc_new;
  logic [2:0]       cc_q;
  m_reg_t           m_load, m_q;

  // NOTE: every signal written here gets a default first so that no path
  // through the case statements leaves it unassigned (which would infer a latch).
  always_comb begin
    alu_a = '0;
    case (E_icode)
      I_RRMOVQ, I_OPQ:             alu_a = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
      I_CALL, I_PUSHQ:             alu_a = -EIGHT;
      I_RET, I_POPQ:               alu_a = EIGHT;
      default:                     alu_a = '0;
    endcase

    alu_b = '0;
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: alu_b = E_valB;
      default:                                                  alu_b = '0;
    endcase

    alu_fun    = (E_icode == I_OPQ) ? E_ifun : ALU_ADD;
    illegal_op = (E_icode == I_OPQ) && (E_ifun > 4'd3);
    alu_res    = alu_calc(alu_fun, alu_a, alu_b);
    cc_new     = {alu_res == '0, alu_res[WIDTH-1], alu_overflow(alu_fun, alu_a, alu_b, alu_res)};

    e_valE = illegal_op ? '0 : alu_res;
    // Conditions read the registered flags, i.e. the value before this edge's update.
    e_Cnd  = ((E_icode == I_JXX) || (E_icode == I_RRMOVQ)) ? cond_eval(E_ifun, cc_q) : 1'b0;
    // A cmovXX whose condition fails must not write its destination.
    e_dstE = ((E_icode == I_RRMOVQ) && !e_Cnd) ? R_NONE : E_dstE;

    set_cc = E_valid && (E_icode == I_OPQ) && !illegal_op && (E_stat == S_AOK)
             && !cc_block && !M_stall;

    m_load = M_BUBBLE;
    if (E_valid) begin
      m_load.valid = 1'b1;
      m_load.stat  = illegal_op ? S_INS : E_stat;
      m_load.icode = E_icode;
      m_load.cnd   = e_Cnd;
      m_load.val_e = e_valE;
      m_load.val_a = E_valA;
      m_load.dst_e = e_dstE;
      m_load.dst_m = E_dstM;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge value of every other register, like real flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_q <= CC_RESET;
      m_q  <= M_BUBBLE;
    end else begin
      if (set_cc) cc_q <= cc_new;
      if (M_bubble)      m_q <= M_BUBBLE;
      else if (!M_stall) m_q <= m_load;
    end
  end

`ifdef EXE_PERF_CNT_EN
  // A "load" is an edge where the M register takes new E-stage contents.
  logic do_load;
  assign do_load = !M_bubble && !M_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_insn_cnt  <= '0;
      perf_taken_cnt <= '0;
    end else if (do_load && E_valid) begin
      perf_insn_cnt <= perf_insn_cnt + 32'd1;
      if ((E_icode == I_JXX) && e_Cnd) perf_taken_cnt <= perf_taken_cnt + 32'd1;
    end
  end
`endif

  assign cc_out  = cc_q;
  assign M_valid = m_q.valid;
  assign M_stat  = m_q.stat;
  assign M_icode = m_q.icode;
  assign M_Cnd   = m_q.cnd;
  assign M_valE  = m_q.val_e;
  assign M_valA  = m_q.val_a;
  assign M_dstE  = m_q.dst_e;
  assign M_dstM  = m_q.dst_m;

endmodule

// File: tb/tb_y86_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_y86_execute_stage
//
// Directed table of E-stage vectors with hand-computed expectations. The
// condition codes carry from row to row, so the rows must run in order after
// reset. Hand-written sequences cover stall, bubble-versus-stall priority and
// reset during a stall.
// ---------------------------------------------------------------------------
module tb_y86_execute_stage;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINS = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAXS = 64'h7FFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        E_valid;
  logic [2:0]  E_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valC, E_valA, E_valB;
  logic        M_stall, M_bubble, cc_block;
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_Cnd;
  logic        M_valid;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE, M_valA;
  logic [3:0]  M_dstE, M_dstM;
  logic [2:0]  cc_out;
`ifdef EXE_PERF_CNT_EN
  logic [31:0] perf_insn_cnt, perf_taken_cnt;
`endif

  y86_execute_stage #(.WIDTH(64), .CC_RESET(3'b100)) dut (
    .clk(clk), .rst(rst),
    .E_valid(E_valid), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .M_stall(M_stall), .M_bubble(M_bubble), .cc_block(cc_block),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
    .M_valid(M_valid), .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
`ifdef EXE_PERF_CNT_EN
    .perf_insn_cnt(perf_insn_cnt), .perf_taken_cnt(perf_taken_cnt),
`endif
    .cc_out(cc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [2:0]  stat;
    logic [3:0]  icode, ifun;
    logic [63:0] val_a, val_b, val_c;
    logic [3:0]  dst_e, dst_m;
    logic        blk;
    logic [63:0] x_vale;
    logic [3:0]  x_dste;
    logic        x_cnd;
    logic [2:0]  x_mstat;
    logic [2:0]  x_cc;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [2:0] st, input logic [3:0] ic,
                              input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] c, input logic [3:0] de, input logic [3:0] dm,
                              input logic blk, input logic [63:0] xv, input logic [3:0] xd,
                              input logic xc, input logic [2:0] xs, input logic [2:0] xcc);
    vec_t r;
    r.valid = v;  r.stat = st;  r.icode = ic;  r.ifun = fn;
    r.val_a = a;  r.val_b = b;  r.val_c = c;   r.dst_e = de; r.dst_m = dm;
    r.blk = blk;  r.x_vale = xv; r.x_dste = xd; r.x_cnd = xc;
    r.x_mstat = xs; r.x_cc = xcc;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    E_valid = v.valid; E_stat = v.stat; E_icode = v.icode; E_ifun = v.ifun;
    E_valA = v.val_a;  E_valB = v.val_b; E_valC = v.val_c;
    E_dstE = v.dst_e;  E_dstM = v.dst_m; cc_block = v.blk;
  endtask

  vec_t tbl[$];
  vec_t s;
  int   exp_insn, exp_taken;

  initial begin
    rst = 1'b1; M_stall = 1'b0; M_bubble = 1'b0;
    drive(mk(0, 1, 1, 0, 0, 0, 0, 4'hF, 4'hF, 0, 0, 4'hF, 0, 1, 0));

    // valid stat icode ifun valA valB valC dstE dstM blk | valE dstE Cnd Mstat cc
    tbl.push_back(mk(1, 1, 4'h6, 0, 64'd39, 64'd9033830, 0, 4'h3, 4'hF, 0, 64'd9033869, 4'h3, 0, 1, 3'b000));
    tbl.push_back(mk(1, 1, 4'h6, 1, 64'd1, MINS, 0, 4'h4, 4'hF, 0, MAXS, 4'h4, 0, 1, 3'b001));
    tbl.push_back(mk(1, 1, 4'h7, 2, 0, 0, 64'h400, 4'hF, 4'hF, 0, 0, 4'hF, 1, 1, 3'b001));
    tbl.push_back(mk(1, 1, 4'h7, 3, 0, 0, 64'h400, 4'hF, 4'hF, 0, 0, 4'hF, 0, 1, 3'b001));
    tbl.push_back(mk(1, 1, 4'h6, 1, 64'd5, 64'd5, 0, 4'h7, 4'hF, 0, 0, 4'h7, 0, 1, 3'b100));
    tbl.push_back(mk(1, 1, 4'h2, 4, 64'h1234, 0, 0, 4'h2, 4'hF, 0, 64'h1234, 4'hF, 0, 1, 3'b100));
    tbl.push_back(mk(1, 1, 4'h2, 0, 64'h55, 0, 0, 4'h2, 4'hF, 0, 64'h55, 4'h2, 1, 1, 3'b100));
    tbl.push_back(mk(1, 1, 4'h6, 2, 64'hF0F0, 64'hFF00, 0, 4'h1, 4'hF, 0, 64'hF000, 4'h1, 0, 1, 3'b000));
    tbl.push_back(mk(1, 1, 4'h6, 3, ONES, 64'h0F, 0, 4'h1, 4'hF, 0, 64'hFFFF_FFFF_FFFF_FFF0, 4'h1, 0, 1, 3'b010));
    tbl.push_back(mk(1, 1, 4'h7, 5, 0, 0, 64'h80, 4'hF, 4'hF, 0, 0, 4'hF, 0, 1, 3'b010));
    tbl.push_back(mk(1, 1, 4'h6, 0, 64'd1, ONES, 0, 4'h3, 4'hF, 1, 0, 4'h3, 0, 1, 3'b010));
    tbl.push_back(mk(1, 1, 4'h6, 7, 64'd3, 64'd4, 0, 4'h3, 4'hF, 0, 0, 4'h3, 0, 4, 3'b010));
    tbl.push_back(mk(1, 1, 4'h3, 0, 0, 0, 64'h42, 4'h5, 4'hF, 0, 64'h42, 4'h5, 0, 1, 3'b010));
    tbl.push_back(mk(1, 1, 4'h5, 0, 0, 64'h1000, 64'd16, 4'hF, 4'h6, 0, 64'h1010, 4'hF, 0, 1, 3'b010));
    tbl.push_back(mk(1, 1, 4'h8, 0, 0, 64'h200, 0, 4'h4, 4'hF, 0, 64'h1F8, 4'h4, 0, 1, 3'b010));
    tbl.push_back(mk(1, 1, 4'hB, 0, 0, 64'h1F8, 0, 4'h4, 4'h6, 0, 64'h200, 4'h4, 0, 1, 3'b010));
    tbl.push_back(mk(1, 3, 4'h6, 0, 64'd1, 64'd2, 0, 4'h3, 4'hF, 0, 64'd3, 4'h3, 0, 3, 3'b010));
    tbl.push_back(mk(0, 1, 4'h6, 0, 64'd1, 64'd1, 0, 4'h3, 4'hF, 0, 64'd2, 4'h3, 0, 1, 3'b010));
    tbl.push_back(mk(1, 1, 4'h6, 0, MAXS, 64'd1, 0, 4'h3, 4'hF, 0, MINS, 4'h3, 0, 1, 3'b011));
    tbl.push_back(mk(1, 1, 4'h7, 6, 0, 0, 64'h10, 4'hF, 4'hF, 0, 0, 4'hF, 1, 1, 3'b011));
    tbl.push_back(mk(1, 1, 4'h0, 0, 64'd7, 64'd9, 0, 4'hF, 4'hF, 0, 0, 4'hF, 0, 1, 3'b011));

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    check("rst cc_out", 64'(cc_out), 64'(3'b100));
    check("rst M_valid", 64'(M_valid), 64'd0);
    check("rst M_icode", 64'(M_icode), 64'h1);
    check("rst M_dstE", 64'(M_dstE), 64'hF);
    check("rst M_valE", M_valE, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    exp_insn = 0;
    exp_taken = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check($sformatf("v%0d e_valE", i), e_valE, tbl[i].x_vale);
      check($sformatf("v%0d e_dstE", i), 64'(e_dstE), 64'(tbl[i].x_dste));
      check($sformatf("v%0d e_Cnd", i), 64'(e_Cnd), 64'(tbl[i].x_cnd));
      @(posedge clk);
      #1;
      check($sformatf("v%0d M_valid", i), 64'(M_valid), 64'(tbl[i].valid));
      check($sformatf("v%0d M_icode", i), 64'(M_icode), tbl[i].valid ? 64'(tbl[i].icode) : 64'h1);
      check($sformatf("v%0d M_stat", i), 64'(M_stat), 64'(tbl[i].x_mstat));
      check($sformatf("v%0d M_valE", i), M_valE, tbl[i].valid ? tbl[i].x_vale : 64'd0);
      check($sformatf("v%0d M_valA", i), M_valA, tbl[i].valid ? tbl[i].val_a : 64'd0);
      check($sformatf("v%0d M_dstE", i), 64'(M_dstE), tbl[i].valid ? 64'(tbl[i].x_dste) : 64'hF);
      check($sformatf("v%0d M_dstM", i), 64'(M_dstM), tbl[i].valid ? 64'(tbl[i].dst_m) : 64'hF);
      check($sformatf("v%0d M_Cnd", i), 64'(M_Cnd), tbl[i].valid ? 64'(tbl[i].x_cnd) : 64'd0);
      check($sformatf("v%0d cc_out", i), 64'(cc_out), 64'(tbl[i].x_cc));
      if (tbl[i].valid) exp_insn++;
      if (tbl[i].valid && tbl[i].icode == 4'h7 && tbl[i].x_cnd) exp_taken++;
    end
`ifdef EXE_PERF_CNT_EN
    check("perf insn", 64'(perf_insn_cnt), 64'(exp_insn));
    check("perf taken", 64'(perf_taken_cnt), 64'(exp_taken));
`endif

    // Stall: M holds an IRMOVQ while PUSHQ waits, then PUSHQ lands.
    @(negedge clk);
    drive(mk(1, 1, 4'h3, 0, 0, 0, 64'h77, 4'h5, 4'hF, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    check("pre-stall M_valE", M_valE, 64'h77);
    @(negedge clk);
    drive(mk(1, 1, 4'hA, 0, 64'h5, 64'h100, 0, 4'h4, 4'hF, 0, 0, 0, 0, 0, 0));
    M_stall = 1'b1;
    #1;
    check("pushq e_valE", e_valE, 64'hF8);
    repeat (2) begin
      @(posedge clk); #1;
      check("stall M_valE", M_valE, 64'h77);
      check("stall M_icode", 64'(M_icode), 64'h3);
    end
    @(negedge clk);
    M_stall = 1'b0;
    @(posedge clk); #1;
    check("post-stall M_valE", M_valE, 64'hF8);
    check("post-stall M_icode", 64'(M_icode), 64'hA);

    // Stall also suppresses the CC update (cc is 011 from the table).
    @(negedge clk);
    drive(mk(1, 1, 4'h6, 1, 64'd5, 64'd5, 0, 4'h3, 4'hF, 0, 0, 0, 0, 0, 0));
    M_stall = 1'b1;
    @(posedge clk); #1;
    check("stall cc hold", 64'(cc_out), 64'(3'b011));
    @(negedge clk);
    M_stall = 1'b0;
    @(posedge clk); #1;
    check("unstall cc", 64'(cc_out), 64'(3'b100));
    check("unstall M_valE", M_valE, 64'd0);

    // Bubble together with stall: bubble wins.
    @(negedge clk);
    drive(mk(1, 1, 4'h3, 0, 0, 0, 64'h99, 4'h5, 4'hF, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    check("pre-bubble M_valE", M_valE, 64'h99);
    @(negedge clk);
    M_bubble = 1'b1;
    M_stall = 1'b1;
    @(posedge clk); #1;
    check("bubble M_valid", 64'(M_valid), 64'd0);
    check("bubble M_icode", 64'(M_icode), 64'h1);
    check("bubble M_valE", M_valE, 64'd0);
    check("bubble M_dstE", 64'(M_dstE), 64'hF);

    // Reset during a stall wins on that edge.
    @(negedge clk);
    M_bubble = 1'b0;
    M_stall = 1'b0;
    drive(mk(1, 1, 4'h6, 0, MAXS, 64'd1, 0, 4'h3, 4'hF, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    check("pre-rst cc", 64'(cc_out), 64'(3'b011));
    check("pre-rst M_valid", 64'(M_valid), 64'd1);
    @(negedge clk);
    M_stall = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst-in-stall cc", 64'(cc_out), 64'(3'b100));
    check("rst-in-stall M_valid", 64'(M_valid), 64'd0);
    check("rst-in-stall M_valE", M_valE, 64'd0);
`ifdef EXE_PERF_CNT_EN
    check("rst perf insn", 64'(perf_insn_cnt), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    M_stall = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
